// File: rtl/bias_loader.sv
`default_nettype none
// ============================================================================
//  Module      : bias_loader
//  Description : Streams NUM_BIAS sign-magnitude bias words from a valid/ready
//                source into a registered bias bank. Negative zero is folded
//                to +0 on write. The module flags completion once every entry
//                has been rewritten, so compute can start on a full bank.
//  Revision    : 1.0  initial release
// ============================================================================
module bias_loader #(
  parameter int NUM_BIAS = 64,
  parameter int DATA_W   = 16,
  parameter int IDX_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [DATA_W-1:0] bias_mem [0:NUM_BIAS-1],
  output logic              busy,
  output logic              load_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0]  C_LAST_IDX = IDX_W'(NUM_BIAS - 1);
  localparam logic [DATA_W-1:0] C_NEG_ZERO = {1'b1, {(DATA_W-1){1'b0}}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_count;
  logic [IDX_W-1:0]  w_count_nxt;
  logic              w_transfer;
  logic              w_wr_en;
  logic [DATA_W-1:0] w_wr_data;

  // A start cycle never takes a beat: the index is being rewound that cycle.
  assign s_ready    = (r_state == ST_LOAD) & ~start;
  assign w_transfer = s_valid & s_ready;

  // Negative zero collapses to +0; every other word passes through untouched.
  assign w_wr_data  = (s_data == C_NEG_ZERO) ? '0 : s_data;

  // Status flags decode the registered state directly.
  assign busy      = (r_state == ST_LOAD);
  assign load_done = (r_state == ST_DONE);

  // State and write-index registers; reset discards any partial load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Next-state, next-index and write-enable decode.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_wr_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_LOAD;
          w_count_nxt = '0;
        end
      end
      ST_LOAD: begin
        if (start) begin
          // Restart: rewind to entry 0, untouched entries keep old contents.
          w_count_nxt = '0;
        end else if (w_transfer) begin
          w_wr_en = 1'b1;
          if (r_count == C_LAST_IDX) begin
            w_state_nxt = ST_DONE;
            w_count_nxt = '0;
          end else begin
            w_count_nxt = r_count + IDX_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_LOAD;
          w_count_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  // Bias bank: cleared on reset, one entry written per accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BIAS; i++) begin
        bias_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      bias_mem[r_count] <= w_wr_data;
    end
  end

endmodule
`default_nettype wire
